// File: rtl/seq_frame_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// the default preamble pattern and a small sizing helper.
package seq_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [4:0] DEFAULT_PREAMBLE = 5'b11101;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Load handshake and serial output bundle of the frame transmitter.
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              dataout;
    logic              busy;
    logic              frame_done;

    modport master (
        output load_valid, load_data,
        input  load_ready, dataout, busy, frame_done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, dataout, busy, frame_done
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then trailing zeros.
// One frame per accepted payload word; all outputs registered.
module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                PRE_W    = 5,
    parameter logic [PRE_W-1:0]  PREAMBLE = PRE_W'(DEFAULT_PREAMBLE),
    parameter int                GAP_LEN  = 1
) (
    input  logic          clock,
    input  logic          reset,
    seq_frame_tx_if.slave bus
);

    localparam int SR_W    = PRE_W + DATA_W;
    localparam int MAX_LEN = max3(PRE_W, DATA_W, GAP_LEN);
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   shreg;
    logic [SR_W-1:0]   frame_word;
    logic              handshake;

    // Preamble and payload share one shifter, so PRE and PAY both emit its MSB.
    assign frame_word = {PREAMBLE, bus.load_data};
    assign handshake  = bus.load_valid && bus.load_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            shreg          <= '0;
            bus.dataout    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.load_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state          <= PRE;
                        cnt            <= CNT_W'(PRE_W - 1);
                        bus.dataout    <= frame_word[SR_W-1];
                        shreg          <= {frame_word[SR_W-2:0], 1'b0};
                        bus.busy       <= 1'b1;
                        bus.load_ready <= 1'b0;
                    end
                end
                PRE, PAY: begin
                    if (cnt != '0) begin
                        cnt         <= cnt - 1'b1;
                        bus.dataout <= shreg[SR_W-1];
                        shreg       <= {shreg[SR_W-2:0], 1'b0};
                    end else if (state == PRE) begin
                        state       <= PAY;
                        cnt         <= CNT_W'(DATA_W - 1);
                        bus.dataout <= shreg[SR_W-1];
                        shreg       <= {shreg[SR_W-2:0], 1'b0};
                    end else begin
                        state          <= GAP;
                        cnt            <= CNT_W'(GAP_LEN - 1);
                        bus.dataout    <= 1'b0;
                        bus.frame_done <= (GAP_LEN == 1);
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt            <= cnt - 1'b1;
                        bus.frame_done <= (cnt == CNT_W'(1));
                    end else begin
                        state          <= IDLE;
                        cnt            <= '0;
                        bus.busy       <= 1'b0;
                        bus.frame_done <= 1'b0;
                        bus.load_ready <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    cnt            <= '0;
                    bus.dataout    <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.frame_done <= 1'b0;
                    bus.load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: reset, single frame, back-to-back,
// payload stability, mid-frame reset and preamble-detector loopback.
module tb_seq_frame_tx;

    localparam int DATA_W = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    seq_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    seq_frame_tx #(
        .DATA_W  (DATA_W),
        .PRE_W   (5),
        .PREAMBLE(5'b11101),
        .GAP_LEN (1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if (bus.dataout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hold: dataout=%b busy=%b frame_done=%b load_ready=%b, required 0 0 0 1",
                     bus.dataout, bus.busy, bus.frame_done, bus.load_ready);
        end
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            tests_run++;
            if (bus.dataout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.load_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL idle_cycle%0d: dataout=%b busy=%b frame_done=%b load_ready=%b, required 0 0 0 1",
                         k, bus.dataout, bus.busy, bus.frame_done, bus.load_ready);
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [13:0] exp_bits;
        exp_bits = {5'b11101, 8'hA5, 1'b0};
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hA5;
        @(posedge clock);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            if (k == 1) bus.load_valid = 1'b0;
            tests_run++;
            if (bus.dataout !== exp_bits[14-k] || bus.busy !== 1'b1 ||
                bus.frame_done !== (k == 14) || bus.load_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL a5_cycle%0d: dataout=%b busy=%b frame_done=%b load_ready=%b, required %b 1 %b 0",
                         k, bus.dataout, bus.busy, bus.frame_done, bus.load_ready, exp_bits[14-k], (k == 14));
            end
        end
        @(negedge clock);
        tests_run++;
        if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.dataout !== 1'b0 || bus.frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL a5_end: load_ready=%b busy=%b dataout=%b frame_done=%b, required 1 0 0 0",
                     bus.load_ready, bus.busy, bus.dataout, bus.frame_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] exp_bits;
        logic        exp_busy;
        exp_bits = {5'b11101, 8'hFF, 1'b0, 1'b0, 5'b11101, 8'h00, 1'b0};
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        @(posedge clock);
        for (int k = 1; k <= 29; k++) begin
            @(negedge clock);
            if (k == 1)  bus.load_data  = 8'h00;
            if (k == 16) bus.load_valid = 1'b0;
            exp_busy = (k != 15);
            tests_run++;
            if (bus.dataout !== exp_bits[29-k] || bus.busy !== exp_busy ||
                bus.load_ready !== !exp_busy || bus.frame_done !== (k == 14 || k == 29)) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d: dataout=%b busy=%b load_ready=%b frame_done=%b, required %b %b %b %b",
                         k, bus.dataout, bus.busy, bus.load_ready, bus.frame_done,
                         exp_bits[29-k], exp_busy, !exp_busy, (k == 14 || k == 29));
            end
        end
    endtask

    task automatic test_hold_data();
        logic [13:0] exp_bits;
        exp_bits = {5'b11101, 8'h3C, 1'b0};
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h3C;
        @(posedge clock);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            bus.load_data  = 8'($urandom);
            bus.load_valid = (k == 14) ? 1'b0 : 1'($urandom);
            tests_run++;
            if (bus.dataout !== exp_bits[14-k] || bus.frame_done !== (k == 14)) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: dataout=%b frame_done=%b, required %b %b",
                         k, bus.dataout, bus.frame_done, exp_bits[14-k], (k == 14));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] exp_bits;
        exp_bits = {5'b11101, 8'hA5, 1'b0};
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hA5;
        @(posedge clock);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) bus.load_valid = 1'b0;
            tests_run++;
            if (bus.dataout !== exp_bits[14-k] || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL abort_pre_cycle%0d: dataout=%b busy=%b, required %b 1",
                         k, bus.dataout, bus.busy, exp_bits[14-k]);
            end
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.dataout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_reset: dataout=%b busy=%b frame_done=%b load_ready=%b, required 0 0 0 1",
                     bus.dataout, bus.busy, bus.frame_done, bus.load_ready);
        end
        #2;
        reset          = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h81;
        exp_bits = {5'b11101, 8'h81, 1'b0};
        @(posedge clock);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            if (k == 1) bus.load_valid = 1'b0;
            tests_run++;
            if (bus.dataout !== exp_bits[14-k] || bus.busy !== 1'b1 || bus.frame_done !== (k == 14)) begin
                tests_failed++;
                $display("FAIL after_abort_cycle%0d: dataout=%b busy=%b frame_done=%b, required %b 1 %b",
                         k, bus.dataout, bus.busy, bus.frame_done, exp_bits[14-k], (k == 14));
            end
        end
    endtask

    task automatic test_loopback();
        logic [4:0] hist;
        int         det_count[4];
        int         done_count;
        hist       = '0;
        done_count = 0;
        for (int f = 0; f < 4; f++) det_count[f] = 0;
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h00;
        @(posedge clock);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 46) bus.load_valid = 1'b0;
            hist = {hist[3:0], bus.dataout};
            if (hist == 5'b11101 && k <= 59) det_count[(k - 1) / 15]++;
            if (bus.frame_done === 1'b1) done_count++;
        end
        for (int f = 0; f < 4; f++) begin
            tests_run++;
            if (det_count[f] !== 1) begin
                tests_failed++;
                $display("FAIL loopback_frame%0d: detections=%0d, required 1", f, det_count[f]);
            end
        end
        tests_run++;
        if (done_count !== 4 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL loopback_done: frame_done_pulses=%0d busy=%b, required 4 0", done_count, bus.busy);
        end
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_hold_data();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (legal range 1..32).
REQ-002 Parameter PRE_W, default 5, preamble length in bits (legal range 1..16).
REQ-003 Parameter PREAMBLE, default 5'b11101, preamble pattern, transmitted MSB first.
REQ-004 Parameter GAP_LEN, default 1, number of trailing zero bits per frame (legal range 1..15).
REQ-005 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port load_valid  input  1  payload-offer qualifier.
REQ-008 Port load_data  input  DATA_W  payload word, sampled only on handshake.
REQ-009 Port load_ready  output  1  block accepts a payload this cycle.
REQ-010 Port dataout  output  1  serial bit stream, registered.
REQ-011 Port busy  output  1  frame in progress.
REQ-012 Port frame_done  output  1  single-cycle pulse marking the final bit of a frame.

Function
REQ-013 The FSM SHALL have states IDLE, PRE, PAY and GAP.
REQ-014 A handshake SHALL occur when load_valid and load_ready are both 1 on a rising edge; load_ready SHALL be 1 only in IDLE.
REQ-015 On handshake, load_data SHALL be captured into a shift register and the state SHALL go IDLE->PRE.
REQ-016 PRE SHALL drive PREAMBLE MSB first, one bit per cycle, for PRE_W cycles, then go to PAY.
REQ-017 PAY SHALL drive the captured word MSB first for DATA_W cycles, then go to GAP.
REQ-018 GAP SHALL drive 0 for GAP_LEN cycles, then go to IDLE.
REQ-019 Latency: with handshake at edge t, dataout SHALL carry preamble bit PRE_W-1 during cycle t+1; a frame SHALL occupy PRE_W+DATA_W+GAP_LEN cycles.
REQ-020 dataout SHALL be 0 in IDLE.
REQ-021 busy SHALL be 1 in PRE, PAY and GAP, and 0 in IDLE.
REQ-022 frame_done SHALL be 1 only during the final GAP cycle.
REQ-023 Changes to load_data or load_valid while busy SHALL have no effect on the frame in flight.
REQ-024 With load_valid held high, the next handshake SHALL occur in the first IDLE cycle, giving exactly one IDLE cycle between frames.
REQ-025 A single bit counter SHALL be sized to hold max(PRE_W, DATA_W, GAP_LEN)-1 and SHALL reload on every state transition.
REQ-026 No escaping of preamble-like patterns in the payload SHALL be performed.

Reset
REQ-027 While reset is 0, the block SHALL be in IDLE with dataout=0, busy=0, frame_done=0, load_ready=1, and the counter and shift register cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse, and discard the captured payload.
REQ-029 The first handshake SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-030 A shared package seq_frame_pkg SHALL hold the state encoding (IDLE/PRE/PAY/GAP) and the default preamble constant 5'b11101.
REQ-031 The block SHALL be a single module with no sub-module; the shifter and counter SHALL be inline.

Verification
REQ-032 Reset then idle 10 cycles -> dataout=0, busy=0, load_ready=1, frame_done never pulses.
REQ-033 Load 8'hA5 at edge t -> dataout over cycles t+1..t+14 reads 1,1,1,0,1, 1,0,1,0,0,1,0,1, 0; frame_done pulses in cycle t+14 only; load_ready=1 at t+15.
REQ-034 load_valid held high with 8'hFF then 8'h00 -> second handshake at t+15 and its preamble starts at t+16; payloads are serialized in order, uncorrupted.
REQ-035 load_data toggled randomly while busy during an 8'h3C frame -> transmitted payload bits are 0,0,1,1,1,1,0,0.
REQ-036 Reset pulsed low during cycle t+8 of an 8'hA5 frame -> dataout=0 and busy=0 immediately, no frame_done; a new 8'h81 load afterwards produces a clean full frame.
REQ-037 Loopback of dataout into the team's 11101 sequence detector with payload 8'h00 -> exactly one detection per frame, for 4 back-to-back frames.
